nec_key_event_queue: RTL and testbench
======================================

NEC_KEY_EVENT_QUEUE -- requirements
Module: nec_key_event_queue

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, event queue depth; SHALL be a power of two, 2..16.
REQ-002 Parameter HOLD_TIMEOUT, default 6000000, cycle window (120 ms at 50 MHz) within which an identical key counts as a repeat.
REQ-003 Parameter STRICT_ADDR, default 1; 1 = require addr[15:8] == ~addr[7:0], 0 = accept a 16-bit extended address unchecked.
REQ-004 clk  input  1  single 50 MHz clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 frame_valid  input  1  data_ready from the IR receiver, level or pulse.
REQ-007 frame_data  input  32  decoded NEC word: [31:24] ~cmd, [23:16] cmd, [15:8] ~addr or addr-high, [7:0] addr.
REQ-008 evt_valid  output  1  queue head holds an event.
REQ-009 evt_ready  input  1  consumer accepts the head.
REQ-010 evt_addr  output  16  head address; {8'h00, addr} when STRICT_ADDR=1, else frame_data[15:0].
REQ-011 evt_cmd  output  8  head command byte.
REQ-012 evt_repeat  output  1  head is a held-key repeat.
REQ-013 evt_rpt_cnt  output  8  head repeat index; 0 for a fresh press.
REQ-014 err_cnt  output  8  saturating count of rejected frames.
REQ-015 overflow  output  1  sticky; an event was dropped because the queue was full.
REQ-016 fifo_level  output  5  entries currently queued.

Function
REQ-017 Frame acceptance SHALL trigger only on a rising edge of frame_valid, detected against a registered copy; a held-high level SHALL yield one frame.
REQ-018 FSM states: IDLE, CHECK. In IDLE, at an edge in cycle N, frame_data SHALL be captured and the FSM SHALL go to CHECK. CHECK SHALL return to IDLE at N+1.
REQ-019 Edges arriving while in CHECK SHALL be ignored, with no error count.
REQ-020 In CHECK the frame SHALL be valid iff cmd == ~inv_cmd and, when STRICT_ADDR=1, the address check also passes.
REQ-021 An invalid frame SHALL increment err_cnt, saturating at 255. It SHALL NOT push an event and SHALL NOT alter the hold timer or the last-key register.
REQ-022 A valid frame SHALL be written to the queue at the end of cycle N+1. With the queue empty, evt_valid SHALL rise at N+2; there is no bypass path.
REQ-023 The hold timer SHALL count up every cycle, saturate at HOLD_TIMEOUT, and clear to 0 on every valid frame.
REQ-024 A valid frame whose {addr,cmd} equals the last valid key while timer < HOLD_TIMEOUT SHALL be a repeat. evt_repeat = 1; evt_rpt_cnt = previous index + 1, saturating at 255.
REQ-025 Any other valid frame SHALL be fresh: evt_repeat = 0, evt_rpt_cnt = 0. The last key SHALL become this key.
REQ-026 Before the first valid frame after reset, no key matches, so the first frame SHALL always be fresh.
REQ-027 Queue head transfer SHALL occur iff evt_valid && evt_ready. evt_* outputs SHALL reflect the head combinationally from storage and SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-028 Push while full without a simultaneous pop: the new event SHALL be dropped, overflow SHALL be set, and the queue SHALL be unchanged.
REQ-029 Push and pop in the same cycle SHALL both complete, including when full (no overflow) and when fifo_level=1. fifo_level SHALL be unchanged.
REQ-030 Pop when empty SHALL have no effect; evt_ready is don't-care while evt_valid=0.
REQ-031 Read and write pointers SHALL wrap modulo FIFO_DEPTH. fifo_level SHALL range 0..FIFO_DEPTH.

Reset
REQ-032 While rst_n=0 at a clock edge, the block SHALL reset: FSM=IDLE, edge register=0, pointers=0, fifo_level=0, evt_valid=0, evt_addr=0, evt_cmd=0, evt_repeat=0, evt_rpt_cnt=0, err_cnt=0, overflow=0, hold timer=HOLD_TIMEOUT, last-key cleared/invalid.
REQ-033 Reset asserted during CHECK SHALL discard the in-flight frame; no push and no error count SHALL occur.
REQ-034 The first edge detection after reset SHALL require frame_valid to be seen low at least once. A level high through reset SHALL NOT produce a frame.

Verification
REQ-035 frame_data=32'hED12_F906 pulsed with the queue empty, evt_ready=0 -> at N+2 evt_valid=1, evt_addr=16'h0006, evt_cmd=8'h12, evt_repeat=0, evt_rpt_cnt=0, fifo_level=1.
REQ-036 Same frame sent 3 times, 1 ms apart, then again 200 ms later (HOLD_TIMEOUT default) -> events with rpt_cnt 0,1,2 (repeat=0,1,1), then a fresh event with repeat=0, rpt_cnt=0.
REQ-037 frame_data=32'h0012_F906 (cmd check fails) -> no event, err_cnt=1; 300 such frames -> err_cnt=255.
REQ-038 evt_ready=0, 5 valid frames with FIFO_DEPTH=4 -> fifo_level=4, overflow=1, head equals the first frame; then drain -> 4 events in order, evt_valid=0 after the last.
REQ-039 Queue full with evt_ready=1 and a push in the same cycle -> fifo_level stays 4, overflow stays 0, order preserved.
REQ-040 frame_valid held high for 100 cycles -> exactly one event; rst_n=0 applied the cycle after the edge -> no event, err_cnt=0, all outputs at reset values.

Source files
------------

// File: rtl/nec_key_event_queue_if.sv
// Event-queue bus for the NEC key event queue: decoded IR frames in,
// queued key events and status out.
interface nec_key_event_queue_if;
  logic        frame_valid;
  logic [31:0] frame_data;
  logic        evt_valid;
  logic        evt_ready;
  logic [15:0] evt_addr;
  logic [7:0]  evt_cmd;
  logic        evt_repeat;
  logic [7:0]  evt_rpt_cnt;
  logic [7:0]  err_cnt;
  logic        overflow;
  logic [4:0]  fifo_level;

  modport slave (
    input  frame_valid, frame_data, evt_ready,
    output evt_valid, evt_addr, evt_cmd, evt_repeat, evt_rpt_cnt,
           err_cnt, overflow, fifo_level
  );

  modport master (
    output frame_valid, frame_data, evt_ready,
    input  evt_valid, evt_addr, evt_cmd, evt_repeat, evt_rpt_cnt,
           err_cnt, overflow, fifo_level
  );
endinterface

// File: rtl/nec_key_event_queue.sv
// Validates decoded NEC frames, classifies held-key repeats and queues the
// resulting key events for a ready/valid consumer.
module nec_key_event_queue #(
  parameter int FIFO_DEPTH   = 4,
  parameter int HOLD_TIMEOUT = 6000000,
  parameter bit STRICT_ADDR  = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  nec_key_event_queue_if.slave  bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [TW-1:0] HOLD_MAX = TW'(HOLD_TIMEOUT);

  typedef enum logic {IDLE, CHECK} state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic        rpt;
    logic [7:0]  rpt_cnt;
  } event_t;

  state_t          state, state_nxt;
  logic            capture, checking;
  logic            fv_q, armed, edge_det;
  logic [31:0]     frame_q;
  logic [TW-1:0]   hold_timer;
  logic            last_vld;
  logic [23:0]     last_key;
  logic [7:0]      last_cnt;

  logic [7:0]      cmd, inv_cmd;
  logic [15:0]     key_addr;
  logic            cmd_ok, addr_ok, frame_ok, frame_bad, is_rpt;
  event_t          new_evt, head;

  event_t          mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [4:0]      level;
  logic            full, push, pop, do_write, drop;

  // armed stays low until frame_valid has been seen low once after reset,
  // so a level held through reset never looks like a fresh edge.
  assign edge_det = bus.frame_valid & ~fv_q & armed;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    checking  = 1'b0;
    case (state)
      IDLE: begin
        if (edge_det) begin
          capture   = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        checking  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign inv_cmd   = frame_q[31:24];
  assign cmd       = frame_q[23:16];
  assign cmd_ok    = (cmd == ~inv_cmd);
  assign addr_ok   = !STRICT_ADDR || (frame_q[15:8] == ~frame_q[7:0]);
  assign key_addr  = STRICT_ADDR ? {8'h00, frame_q[7:0]} : frame_q[15:0];
  assign frame_ok  = checking & cmd_ok & addr_ok;
  assign frame_bad = checking & ~(cmd_ok & addr_ok);

  assign is_rpt = last_vld && (last_key == {key_addr, cmd}) && (hold_timer < HOLD_MAX);

  always_comb begin
    new_evt.addr    = key_addr;
    new_evt.cmd     = cmd;
    new_evt.rpt     = is_rpt;
    new_evt.rpt_cnt = 8'h00;
    if (is_rpt) new_evt.rpt_cnt = (last_cnt == 8'hFF) ? 8'hFF : last_cnt + 8'd1;
  end

  // A pop frees a slot in the same cycle, so a push into a full queue with
  // a simultaneous pop still lands.
  assign full     = (level == 5'(FIFO_DEPTH));
  assign pop      = bus.evt_valid & bus.evt_ready;
  assign push     = frame_ok;
  assign do_write = push & (~full | pop);
  assign drop     = push & full & ~pop;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      fv_q         <= 1'b0;
      armed        <= 1'b0;
      frame_q      <= '0;
      hold_timer   <= HOLD_MAX;
      last_vld     <= 1'b0;
      last_key     <= '0;
      last_cnt     <= '0;
      bus.err_cnt  <= '0;
      bus.overflow <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      level        <= '0;
    end else begin
      state <= state_nxt;
      fv_q  <= bus.frame_valid;
      if (!bus.frame_valid) armed <= 1'b1;
      if (capture) frame_q <= bus.frame_data;

      if (frame_ok)                   hold_timer <= '0;
      else if (hold_timer < HOLD_MAX) hold_timer <= hold_timer + TW'(1);

      if (frame_ok) begin
        last_vld <= 1'b1;
        last_key <= {key_addr, cmd};
        last_cnt <= new_evt.rpt_cnt;
      end

      if (frame_bad && bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
      if (drop) bus.overflow <= 1'b1;

      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      if (do_write) wr_ptr <= wr_ptr + PW'(1);
      case ({do_write, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: queue storage is deliberately not reset; reads are gated by
  // evt_valid, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= new_evt;
  end

  assign head            = mem[rd_ptr];
  assign bus.fifo_level  = level;
  assign bus.evt_valid   = (level != 5'd0);
  assign bus.evt_addr    = bus.evt_valid ? head.addr    : 16'h0000;
  assign bus.evt_cmd     = bus.evt_valid ? head.cmd     : 8'h00;
  assign bus.evt_repeat  = bus.evt_valid ? head.rpt     : 1'b0;
  assign bus.evt_rpt_cnt = bus.evt_valid ? head.rpt_cnt : 8'h00;

endmodule

// File: tb/tb_nec_key_event_queue.sv
// Self-checking bench for nec_key_event_queue: hand-written vector table,
// corner-case sequences and randomized traffic against a queue-based model.
module tb_nec_key_event_queue;
  localparam int DEPTH = 4;
  localparam int HT    = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nec_key_event_queue_if bus ();

  nec_key_event_queue #(
    .FIFO_DEPTH  (DEPTH),
    .HOLD_TIMEOUT(HT),
    .STRICT_ADDR (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] addr;
    logic [7:0]  cmd;
    bit          rpt;
    logic [7:0]  cnt;
  } ev_t;

  ev_t         m_q[$];
  bit          m_prev_fv, m_armed, m_pend, m_ovf, m_last_vld;
  logic [31:0] m_data;
  logic [23:0] m_last_key;
  int          m_err, m_last_cnt;
  longint      m_last_cyc, cyc = 0;

  task automatic model_step();
    ev_t         e;
    bit          pop, push, ok, rpt, full, edge_seen;
    logic [7:0]  c;
    logic [23:0] key;
    int          n;
    if (!rst_n) begin
      m_q.delete();
      m_prev_fv = 0; m_armed = 0; m_pend = 0; m_ovf = 0; m_last_vld = 0;
      m_err = 0; m_last_cnt = 0;
      return;
    end
    pop  = (m_q.size() > 0) && bus.evt_ready;
    push = 0;
    if (m_pend) begin
      c  = m_data[23:16];
      ok = (m_data[31:24] == (8'hFF ^ c)) && (m_data[15:8] == (8'hFF ^ m_data[7:0]));
      if (!ok) begin
        if (m_err < 255) m_err++;
      end else begin
        key    = {8'h00, m_data[7:0], c};
        rpt    = m_last_vld && (key == m_last_key) && ((cyc - m_last_cyc) <= HT);
        n      = rpt ? ((m_last_cnt >= 255) ? 255 : m_last_cnt + 1) : 0;
        e.addr = {8'h00, m_data[7:0]};
        e.cmd  = c;
        e.rpt  = rpt;
        e.cnt  = 8'(n);
        m_last_vld = 1; m_last_key = key; m_last_cnt = n; m_last_cyc = cyc;
        push = 1;
      end
    end
    full = (m_q.size() == DEPTH);
    if (push && full && !pop) m_ovf = 1;
    else begin
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(e);
    end
    edge_seen = bus.frame_valid && !m_prev_fv && m_armed && !m_pend;
    if (edge_seen) m_data = bus.frame_data;
    m_pend = edge_seen;
    if (!bus.frame_valid) m_armed = 1;
    m_prev_fv = bus.frame_valid;
  endtask

  task automatic compare_model();
    check("m.evt_valid",  32'(bus.evt_valid),  32'(m_q.size() > 0));
    check("m.fifo_level", 32'(bus.fifo_level), 32'(m_q.size()));
    check("m.err_cnt",    32'(bus.err_cnt),    32'(m_err));
    check("m.overflow",   32'(bus.overflow),   32'(m_ovf));
    if (m_q.size() > 0) begin
      check("m.evt_addr",    32'(bus.evt_addr),    32'(m_q[0].addr));
      check("m.evt_cmd",     32'(bus.evt_cmd),     32'(m_q[0].cmd));
      check("m.evt_repeat",  32'(bus.evt_repeat),  32'(m_q[0].rpt));
      check("m.evt_rpt_cnt", 32'(bus.evt_rpt_cnt), 32'(m_q[0].cnt));
    end else begin
      check("m.idle_addr", 32'(bus.evt_addr), 32'h0);
      check("m.idle_fld",  {bus.evt_cmd, bus.evt_rpt_cnt, 7'd0, bus.evt_repeat}, 32'h0);
    end
  endtask

  // Inputs are changed only at #1 after a posedge, so the model sees the
  // same values the DUT sampled.
  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.frame_valid = 1'b0;
    bus.evt_ready   = 1'b0;
    bus.frame_data  = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send(input logic [31:0] d);
    bus.frame_data  = d;
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    bus.evt_ready = 1'b1;
    tick();
    bus.evt_ready = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [7:0] c);
    return {8'hFF ^ c, c, 16'hF906};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] data;
    int          gap;
    bit          evt;
    logic [15:0] addr;
    logic [7:0]  cmd;
    bit          rpt;
    logic [7:0]  cnt;
    logic [7:0]  err;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #(5ms);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'hED12_F906,   5, 1, 16'h0006, 8'h12, 0, 8'd0, 8'd0};
    tbl[1]  = '{32'hED12_F906,  20, 1, 16'h0006, 8'h12, 1, 8'd1, 8'd0};
    tbl[2]  = '{32'hED12_F906,  20, 1, 16'h0006, 8'h12, 1, 8'd2, 8'd0};
    tbl[3]  = '{32'hED12_F906, 400, 1, 16'h0006, 8'h12, 0, 8'd0, 8'd0};
    tbl[4]  = '{32'h0012_F906,   5, 0, 16'h0000, 8'h00, 0, 8'd0, 8'd1};
    tbl[5]  = '{32'hED12_F906,  20, 1, 16'h0006, 8'h12, 1, 8'd1, 8'd1};
    tbl[6]  = '{32'h01FE_F906,   5, 1, 16'h0006, 8'hFE, 0, 8'd0, 8'd1};
    tbl[7]  = '{32'h01FE_1234,   5, 0, 16'h0000, 8'h00, 0, 8'd0, 8'd2};
    tbl[8]  = '{32'h7F80_00FF,   5, 1, 16'h00FF, 8'h80, 0, 8'd0, 8'd2};
    tbl[9]  = '{32'h7F80_00FF, 197, 1, 16'h00FF, 8'h80, 1, 8'd1, 8'd2};
    tbl[10] = '{32'h7F80_00FF, 198, 1, 16'h00FF, 8'h80, 0, 8'd0, 8'd2};

    bus.frame_valid = 1'b0;
    bus.frame_data  = '0;
    bus.evt_ready   = 1'b0;

    // Reset state
    do_reset();
    check("reset.evt_valid",  32'(bus.evt_valid),  32'h0);
    check("reset.fifo_level", 32'(bus.fifo_level), 32'h0);
    check("reset.err_cnt",    32'(bus.err_cnt),    32'h0);

    // Table: isolated frames, head checked at N+2, then popped
    for (int i = 0; i < 11; i++) begin
      repeat (tbl[i].gap) tick();
      send(tbl[i].data);
      check($sformatf("tbl%0d.evt_valid", i), 32'(bus.evt_valid), 32'(tbl[i].evt));
      check($sformatf("tbl%0d.err_cnt", i),   32'(bus.err_cnt),   32'(tbl[i].err));
      if (tbl[i].evt) begin
        check($sformatf("tbl%0d.level", i),   32'(bus.fifo_level),  32'd1);
        check($sformatf("tbl%0d.addr", i),    32'(bus.evt_addr),    32'(tbl[i].addr));
        check($sformatf("tbl%0d.cmd", i),     32'(bus.evt_cmd),     32'(tbl[i].cmd));
        check($sformatf("tbl%0d.repeat", i),  32'(bus.evt_repeat),  32'(tbl[i].rpt));
        check($sformatf("tbl%0d.rpt_cnt", i), 32'(bus.evt_rpt_cnt), 32'(tbl[i].cnt));
        pop_one();
      end
    end

    // Overflow: five frames into a depth-4 queue, then drain in order
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      repeat (3) tick();
      send(mk(8'(i)));
    end
    check("ovf.level",    32'(bus.fifo_level), 32'd4);
    check("ovf.overflow", 32'(bus.overflow),   32'd1);
    check("ovf.head",     32'(bus.evt_cmd),    32'h01);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovf.drain%0d", i), 32'(bus.evt_cmd), 32'(i));
      pop_one();
    end
    check("ovf.empty", 32'(bus.evt_valid), 32'd0);

    // Full queue with push and pop in the same cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      repeat (3) tick();
      send(mk(8'(8'h11 + i)));
    end
    bus.frame_data  = mk(8'h15);
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    bus.evt_ready   = 1'b1;
    tick();
    bus.evt_ready   = 1'b0;
    check("full_pp.level",    32'(bus.fifo_level), 32'd4);
    check("full_pp.overflow", 32'(bus.overflow),   32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("full_pp.drain%0d", i), 32'(bus.evt_cmd), 32'(8'h12 + i));
      pop_one();
    end

    // Held-high level yields exactly one frame
    do_reset();
    bus.frame_data  = 32'hED12_F906;
    bus.frame_valid = 1'b1;
    repeat (100) tick();
    bus.frame_valid = 1'b0;
    tick();
    check("held.level", 32'(bus.fifo_level), 32'd1);

    // Reset during CHECK discards the frame
    do_reset();
    send(32'h0012_F906);
    check("rst_chk.pre_err", 32'(bus.err_cnt), 32'd1);
    bus.frame_data  = 32'hED12_F906;
    bus.frame_valid = 1'b1;
    tick();
    rst_n = 1'b0;
    bus.frame_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst_chk.level",   32'(bus.fifo_level), 32'd0);
    check("rst_chk.err_cnt", 32'(bus.err_cnt),    32'd0);
    check("rst_chk.outs",    {bus.evt_addr, bus.evt_cmd, bus.evt_rpt_cnt}, 32'h0);

    // Level held high through reset release must not create a frame
    rst_n = 1'b0;
    bus.frame_valid = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("rst_lvl.level", 32'(bus.fifo_level), 32'd0);
    bus.frame_valid = 1'b0;
    tick();
    send(32'hED12_F906);
    check("rst_lvl.after", 32'(bus.fifo_level), 32'd1);
    check("rst_lvl.fresh", 32'(bus.evt_repeat), 32'd0);

    // Error counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send(32'h0012_F906);
      if (i == 0) check("err.first", 32'(bus.err_cnt), 32'd1);
    end
    check("err.sat",   32'(bus.err_cnt),    32'd255);
    check("err.level", 32'(bus.fifo_level), 32'd0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.frame_valid = ~bus.frame_valid;
      case ($urandom_range(0, 5))
        0: bus.frame_data = 32'hED12_F906;
        1: bus.frame_data = 32'h01FE_F906;
        2: bus.frame_data = 32'h7F80_00FF;
        3: bus.frame_data = 32'h0012_F906;
        4: bus.frame_data = 32'h01FE_1234;
        default: ;
      endcase
      bus.evt_ready = ($urandom_range(0, 7) < ((i < 2000) ? 1 : 4));
      if ($urandom_range(0, 299) == 0) begin
        bus.frame_valid = 1'b0;
        repeat (HT + $urandom_range(0, 10)) tick();
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
